uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 141 ++++++++++++++
 tb/tb_uart_rx_os.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver for the debug link.
// Bytes are held for Debug behind a level ready / pulse clear handshake.
module uart_rx_os #(
  parameter int CLK_FR      = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int RX_DIV_SAMP = 16,
  parameter int DBIT        = 8
) (
  input  logic            clk_wz,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_rx_clear,
  output logic [DBIT-1:0] o_rx_data,
  output logic            o_rx_ready,
  output logic            o_frame_err,
  output logic            o_overrun
);

  localparam int DIV = CLK_FR / (BAUD_RATE * RX_DIV_SAMP);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (RX_DIV_SAMP > 2) ? $clog2(RX_DIV_SAMP) : 1;
  localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_MID    = SW'(RX_DIV_SAMP / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(RX_DIV_SAMP - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic            s_tick;
  logic            rx_m;
  logic            rx_s;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] sh;

  assign s_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_wz) begin
    if (i_reset) begin
      div_cnt <= '0;
    end else if (s_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Line idles high, so the synchronizer resets to the idle level.
  always_ff @(posedge clk_wz) begin
    if (i_reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_wz) begin
    if (i_reset) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n           <= '0;
      sh          <= '0;
      o_rx_data   <= '0;
      o_rx_ready  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      if (i_rx_clear) begin
        o_rx_ready <= 1'b0;
        o_overrun  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == S_MID) begin
              s_cnt <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              sh    <= {rx_s, sh[DBIT-1:1]};
              s_cnt <= '0;
              n     <= n + NW'(1);
              if (n == N_LAST) begin
                state <= STOP;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt == S_LAST) begin
              state <= IDLE;
              s_cnt <= '0;
              // A completing frame overrides a same-cycle clear.
              if (rx_s) begin
                o_rx_data  <= sh;
                o_rx_ready <= 1'b1;
                if (o_rx_ready && !i_rx_clear) begin
                  o_overrun <= 1'b1;
                end
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV = 10 (160-cycle bit period).
// Completion edges are predicted from the known tick phase after reset.
module tb_uart_rx_os;

  localparam int CLK_FR = 1600;
  localparam int BAUD   = 10;
  localparam int OS     = 16;
  localparam int DBIT   = 8;
  localparam int DIV    = 10;
  localparam int BIT    = OS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       ferr;
  logic       ovr;

  int n_chk    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int rst_edge = 0;
  int k;
  int e;
  logic [7:0] seq [5] = '{8'h00, 8'h22, 8'h20, 8'h20, 8'hFF};
  logic [7:0] cut     = 8'h3C;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ferr) fe_cnt <= fe_cnt + 1;
  end

  uart_rx_os #(
    .CLK_FR     (CLK_FR),
    .BAUD_RATE  (BAUD),
    .RX_DIV_SAMP(OS),
    .DBIT       (DBIT)
  ) dut (
    .clk_wz     (clk),
    .i_reset    (rst),
    .i_rx       (rx),
    .i_rx_clear (clr),
    .o_rx_data  (data),
    .o_rx_ready (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic b, input int len);
    rx = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_stop);
    send_bits(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bits(d[i], BIT);
    if (bad_stop) begin
      send_bits(1'b0, 100);
      send_bits(1'b1, BIT - 100);
    end else begin
      send_bits(1'b1, BIT);
    end
  endtask

  // Edge at which a frame whose start bit was driven after edge k completes.
  function automatic int done_edge(input int kk);
    int t;
    t = kk + 4;
    while ((t - rst_edge) % DIV != 0) t++;
    return t + (OS / 2 - 1) * DIV + (DBIT + 1) * BIT;
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (!ready && i < 20 * BIT) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst_edge = cyc;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    chk("rst data", data, 0);
    chk("rst ready", ready, 0);
    chk("rst ferr", ferr, 0);
    chk("rst ovr", ovr, 0);
    repeat (5) @(posedge clk);
    #1;

    k = cyc;
    e = done_edge(k);
    fork
      send_frame(8'h64, 1'b0);
      begin
        wait_cyc(e - 1);
        chk("t1 early", ready, 0);
        wait_cyc(e);
        chk("t1 ready", ready, 1);
        chk("t1 data", data, 8'h64);
      end
    join
    chk("t1 ferr", fe_cnt, 0);
    chk("t1 ovr", ovr, 0);
    pulse_clear();
    chk("t1 clear", ready, 0);

    fork
      for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b0);
      for (int j = 0; j < 5; j++) begin
        wait_ready("t2 wait");
        chk("t2 data", data, seq[j]);
        pulse_clear();
        chk("t2 clear", ready, 0);
      end
    join
    chk("t2 ovr", ovr, 0);
    chk("t2 ferr", fe_cnt, 0);

    send_frame(8'hA5, 1'b1);
    send_bits(1'b1, 400);
    chk("t3 ferr", fe_cnt, 1);
    chk("t3 ready", ready, 0);
    chk("t3 data", data, 8'hFF);

    send_bits(1'b0, 40);
    send_bits(1'b1, 400);
    chk("glitch ready", ready, 0);
    chk("glitch ferr", fe_cnt, 1);
    chk("glitch ovr", ovr, 0);

    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    chk("t4 data", data, 8'h22);
    chk("t4 ready", ready, 1);
    chk("t4 ovr", ovr, 1);
    pulse_clear();
    chk("t4 clr ready", ready, 0);
    chk("t4 clr ovr", ovr, 0);

    send_frame(8'h81, 1'b0);
    send_frame(8'h42, 1'b0);
    chk("t5 pre ovr", ovr, 1);
    chk("t5 pre data", data, 8'h42);
    send_bits(1'b0, BIT);
    for (int i = 0; i < 3; i++) send_bits(cut[i], BIT);
    send_bits(cut[3], BIT / 2);
    rx = 1'b1;
    do_reset();
    chk("t5 rst data", data, 0);
    chk("t5 rst ready", ready, 0);
    chk("t5 rst ovr", ovr, 0);
    chk("t5 rst ferr", ferr, 0);
    send_bits(1'b1, 200);
    send_frame(8'h63, 1'b0);
    chk("t5 data", data, 8'h63);
    chk("t5 ready", ready, 1);
    chk("t5 ovr", ovr, 0);

    k = cyc;
    e = done_edge(k);
    fork
      send_frame(8'h5A, 1'b0);
      begin
        wait_cyc(e - 1);
        chk("t6 pre ready", ready, 1);
        clr = 1'b1;
        wait_cyc(e);
        clr = 1'b0;
        chk("t6 ready", ready, 1);
        chk("t6 data", data, 8'h5A);
        chk("t6 ovr", ovr, 0);
      end
    join
    pulse_clear();
    chk("t6 clear", ready, 0);
    chk("end ferr", fe_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
